segment_scan_decoder: RTL and testbench

Passive monitor for the multiplexed four-digit seven-segment bus (`DIG`/`SEG`) driven by the clock display. It samples the scanned select and segment pins, waits for each digit slot to settle, decodes the pattern back to BCD, and publishes one coherent 4-digit frame per scan pass. It is used for on-board self-check and for bench loopback of the display path, and has no influence on the display itself.

---
 rtl/segment_scan_decoder.sv | 182 ++++++++++++++++++
 tb/tb_segment_scan_decoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/segment_scan_decoder.sv
// Passive decoder for the scanned 4-digit seven-segment bus; publishes one coherent frame per scan pass.
// Latency: 2 sync + SETTLE + 1 cycles from pin change to capture; frame outputs update on the capture edge that closes a pass.
// Backpressure: none. This is a pure monitor, so the bus is never stalled and outputs are held until the next publish.
module segment_scan_decoder #(
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter int SETTLE         = 2,
    parameter int TIMEOUT        = 4096
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [3:0]  dig_in,
    input  logic [7:0]  seg_in,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic [3:0]  dp,
    output logic [3:0]  invalid,
    output logic        frame_strobe,
    output logic        frame_valid,
    output logic        stale
);

    localparam logic [3:0] DIG_OFF = DIG_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam int         IW      = $clog2(TIMEOUT + 1);

    logic [3:0]       r_dig_s1, r_dig_s2;
    logic [7:0]       r_seg_s1, r_seg_s2;
    logic [3:0]       r_settle;
    logic             r_held;
    logic [3:0][3:0]  r_sh_val;
    logic [3:0]       r_sh_blank, r_sh_dp, r_sh_inv, r_seen;
    logic [1:0]       r_last_k;
    logic [IW-1:0]    r_idle;
    logic [15:0]      r_digits;
    logic [3:0]       r_blank, r_dp, r_inv;
    logic             r_strobe, r_fvalid, r_stale;

    logic [3:0]       w_dig;
    logic [7:0]       w_seg;
    logic             w_stable, w_dig_chg, w_onehot, w_capture, w_close;
    logic [1:0]       w_slot, w_k;
    logic [3:0]       w_val;
    logic             w_blank, w_inv;

    // XOR with the idle level turns both buses active-high.
    assign w_dig     = r_dig_s2 ^ DIG_OFF;
    assign w_seg     = r_seg_s2 ^ SEG_OFF;
    // s1 holds the value s2 will take next, so equality means the bus is holding still.
    assign w_dig_chg = (r_dig_s1 != r_dig_s2);
    assign w_stable  = !w_dig_chg && (r_seg_s1 == r_seg_s2);
    assign w_onehot  = (w_dig != 4'd0) && ((w_dig & (w_dig - 4'd1)) == 4'd0);
    assign w_capture = w_onehot && w_stable && (r_settle == 4'(SETTLE)) && !r_held;
    // k is the position in scan order (leftmost first), so a pass runs with increasing k.
    assign w_k       = 2'd3 - w_slot;
    assign w_close   = w_capture && (w_k <= r_last_k) && (r_seen != 4'd0);

    // Two-flop synchronizers, reset to the idle pin level.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_dig_s1 <= DIG_OFF;
            r_dig_s2 <= DIG_OFF;
            r_seg_s1 <= SEG_OFF;
            r_seg_s2 <= SEG_OFF;
        end else begin
            r_dig_s1 <= dig_in;
            r_dig_s2 <= r_dig_s1;
            r_seg_s1 <= seg_in;
            r_seg_s2 <= r_seg_s1;
        end
    end

    // Settle counter; r_held blocks repeat captures until the selection moves.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_settle <= 4'd0;
            r_held   <= 1'b0;
        end else begin
            if (!w_stable)
                r_settle <= 4'd0;
            else if (r_settle != 4'(SETTLE))
                r_settle <= r_settle + 4'd1;
            if (w_dig_chg)
                r_held <= 1'b0;
            else if (w_capture)
                r_held <= 1'b1;
        end
    end

    // Slot index of the one-hot select (only meaningful when w_onehot).
    always_comb begin
        w_slot = 2'd0;
        case (w_dig)
            4'b0010: w_slot = 2'd1;
            4'b0100: w_slot = 2'd2;
            4'b1000: w_slot = 2'd3;
            default: w_slot = 2'd0;
        endcase
    end

    // Segment pattern back to BCD; unknown patterns report 0xF and invalid.
    always_comb begin
        w_val   = 4'hF;
        w_blank = 1'b0;
        w_inv   = 1'b0;
        case (w_seg[6:0])
            7'h3F: w_val = 4'd0;
            7'h06: w_val = 4'd1;
            7'h5B: w_val = 4'd2;
            7'h4F: w_val = 4'd3;
            7'h66: w_val = 4'd4;
            7'h6D: w_val = 4'd5;
            7'h7D: w_val = 4'd6;
            7'h07: w_val = 4'd7;
            7'h7F: w_val = 4'd8;
            7'h6F: w_val = 4'd9;
            7'h00: begin w_val = 4'd0; w_blank = 1'b1; end
            default: w_inv = 1'b1;
        endcase
    end

    // Shadow bank, pass closing/publish and staleness tracking.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_sh_val   <= '0;
            r_sh_blank <= 4'd0;
            r_sh_dp    <= 4'd0;
            r_sh_inv   <= 4'd0;
            r_seen     <= 4'd0;
            r_last_k   <= 2'd0;
            r_idle     <= '0;
            r_digits   <= 16'd0;
            r_blank    <= 4'hF;
            r_dp       <= 4'd0;
            r_inv      <= 4'd0;
            r_strobe   <= 1'b0;
            r_fvalid   <= 1'b0;
            r_stale    <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_capture) begin
                r_sh_val[w_slot]   <= w_val;
                r_sh_blank[w_slot] <= w_blank;
                r_sh_dp[w_slot]    <= w_seg[7];
                r_sh_inv[w_slot]   <= w_inv;
                r_last_k           <= w_k;
                r_idle             <= '0;
                r_stale            <= 1'b0;
                if (w_close) begin
                    // Unseen slots go out dark so a short scan never shows old digits.
                    for (int i = 0; i < 4; i++) begin
                        r_digits[4*i +: 4] <= r_seen[i] ? r_sh_val[i] : 4'd0;
                        r_blank[i]         <= r_seen[i] ? r_sh_blank[i] : 1'b1;
                        r_dp[i]            <= r_seen[i] & r_sh_dp[i];
                        r_inv[i]           <= r_seen[i] & r_sh_inv[i];
                    end
                    r_strobe <= 1'b1;
                    r_fvalid <= 1'b1;
                    r_seen   <= w_dig;
                end else begin
                    r_seen <= r_seen | w_dig;
                end
            end else if (r_idle != IW'(TIMEOUT)) begin
                r_idle <= r_idle + 1'b1;
                if (r_idle == IW'(TIMEOUT - 1)) begin
                    r_stale  <= 1'b1;
                    r_fvalid <= 1'b0;
                    r_seen   <= 4'd0;
                end
            end
        end
    end

    assign digits       = r_digits;
    assign blank        = r_blank;
    assign dp           = r_dp;
    assign invalid      = r_inv;
    assign frame_strobe = r_strobe;
    assign frame_valid  = r_fvalid;
    assign stale        = r_stale;

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Directed bench for segment_scan_decoder: expected frames go into a queue, a monitor checks each strobe.
// Latency: frames are expected only when the next pass's first capture closes the current one.
// Backpressure: none; the bench drives the scan bus freely with active-low pins.
module tb_segment_scan_decoder;

    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 4096;
    localparam int HOLD    = 16;
    localparam logic [6:0] SEG_TAB [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  blank;
        logic [3:0]  dp;
        logic [3:0]  invalid;
    } frame_t;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b0;
    logic [3:0]  dig_in = 4'hF;
    logic [7:0]  seg_in = 8'hFF;
    logic [15:0] digits;
    logic [3:0]  blank, dp, invalid;
    logic        frame_strobe, frame_valid, stale;

    frame_t exp_q[$];
    frame_t mon_f;
    int     n_cmp = 0;
    int     n_err = 0;

    segment_scan_decoder #(
        .DIG_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_in(clk_in), .reset(reset), .dig_in(dig_in), .seg_in(seg_in),
        .digits(digits), .blank(blank), .dp(dp), .invalid(invalid),
        .frame_strobe(frame_strobe), .frame_valid(frame_valid), .stale(stale)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dg(input int d, input bit dpb);
        logic [6:0] p;
        p = SEG_TAB[d];
        return {dpb, p};
    endfunction

    function automatic frame_t mk(input logic [15:0] d, input logic [3:0] b,
                                  input logic [3:0] p, input logic [3:0] v);
        frame_t f;
        f.digits = d; f.blank = b; f.dp = p; f.invalid = v;
        return f;
    endfunction

    // Drive one slot (active-high pattern) for a number of cycles; called and returns at a negedge.
    task automatic show(input int slot, input logic [7:0] pat, input int hold);
        logic [3:0] one;
        one    = 4'b0001;
        dig_in = ~(one << slot);
        seg_in = ~pat;
        repeat (hold) @(negedge clk_in);
    endtask

    task automatic idle_bus(input int n);
        dig_in = 4'hF;
        seg_in = 8'hFF;
        repeat (n) @(negedge clk_in);
    endtask

    task automatic pass4(input logic [7:0] p3, input logic [7:0] p2,
                         input logic [7:0] p1, input logic [7:0] p0);
        show(3, p3, HOLD);
        show(2, p2, HOLD);
        show(1, p1, HOLD);
        show(0, p0, HOLD);
    endtask

    task automatic pass3(input logic [7:0] p2, input logic [7:0] p1, input logic [7:0] p0);
        show(2, p2, HOLD);
        show(1, p1, HOLD);
        show(0, p0, HOLD);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_digits"},  digits, 16'h0000);
        check({tag, "_blank"},   16'(blank), 16'hF);
        check({tag, "_dp"},      16'(dp), 16'h0);
        check({tag, "_invalid"}, 16'(invalid), 16'h0);
        check({tag, "_strobe"},  16'(frame_strobe), 16'h0);
        check({tag, "_fvalid"},  16'(frame_valid), 16'h0);
        check({tag, "_stale"},   16'(stale), 16'h0);
    endtask

    // Scoreboard monitor: every published frame must match the oldest expectation.
    always @(negedge clk_in) begin
        if (reset && frame_strobe) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_strobe: got strobe with digits %h, expected no frame", digits);
            end else begin
                mon_f = exp_q.pop_front();
                check("frame_digits",  digits, mon_f.digits);
                check("frame_blank",   16'(blank), 16'(mon_f.blank));
                check("frame_dp",      16'(dp), 16'(mon_f.dp));
                check("frame_invalid", 16'(invalid), 16'(mon_f.invalid));
                check("frame_valid_at_strobe", 16'(frame_valid), 16'h1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish before 1ms");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk_in);
        repeat (3) @(negedge clk_in);
        check_reset_vals("rst");
        reset = 1'b1;
        idle_bus(4);

        // "12:34" with the colon on the '2' digit; second pass closes the first.
        pass4(dg(1, 1'b0), dg(2, 1'b1), dg(3, 1'b0), dg(4, 1'b0));
        exp_q.push_back(mk(16'h1234, 4'b0000, 4'b0100, 4'b0000));
        pass4(dg(1, 1'b0), dg(2, 1'b1), dg(3, 1'b0), dg(4, 1'b0));
        exp_q.push_back(mk(16'h1234, 4'b0000, 4'b0100, 4'b0000));

        // Three-digit mode, leftmost slot not scanned.
        pass3(dg(9, 1'b0), dg(5, 1'b0), dg(9, 1'b0));
        check("fvalid_after_1234", 16'(frame_valid), 16'h1);
        check("digits_held_1234", digits, 16'h1234);
        exp_q.push_back(mk(16'h0959, 4'b1000, 4'b0000, 4'b0000));
        pass3(dg(9, 1'b0), dg(5, 1'b0), dg(9, 1'b0));
        exp_q.push_back(mk(16'h0959, 4'b1000, 4'b0000, 4'b0000));

        // Illegal pattern 0x49 on slot 0.
        pass4(dg(7, 1'b0), dg(0, 1'b0), dg(8, 1'b0), 8'h49);
        exp_q.push_back(mk(16'h708F, 4'b0000, 4'b0000, 4'b0001));
        pass4(dg(7, 1'b0), dg(0, 1'b0), dg(8, 1'b0), 8'h49);

        // Too-short holds and a two-hot select never capture; then the bus goes quiet.
        for (int s = 3; s >= 0; s--) show(s, dg(s, 1'b0), SETTLE + 1);
        dig_in = 4'b0011;
        seg_in = ~dg(8, 1'b0);
        repeat (20) @(negedge clk_in);
        idle_bus(3850);
        check("stale_before_timeout", 16'(stale), 16'h0);
        idle_bus(250);
        check("stale_after_timeout", 16'(stale), 16'h1);
        check("fvalid_cleared_by_stale", 16'(frame_valid), 16'h0);
        check("digits_held_stale", digits, 16'h708F);
        check("invalid_held_stale", 16'(invalid), 16'h1);

        // Recovery: first capture clears stale, next publish sets frame_valid.
        show(3, dg(1, 1'b0), HOLD);
        check("stale_cleared_on_capture", 16'(stale), 16'h0);
        check("fvalid_low_until_publish", 16'(frame_valid), 16'h0);
        show(2, dg(2, 1'b0), HOLD);
        show(1, dg(3, 1'b0), HOLD);
        show(0, dg(4, 1'b0), HOLD);
        exp_q.push_back(mk(16'h1234, 4'b0000, 4'b0000, 4'b0000));
        show(3, dg(5, 1'b0), HOLD);
        show(2, dg(6, 1'b0), HOLD);
        check("fvalid_after_recovery", 16'(frame_valid), 16'h1);

        // Reset mid-pass, away from any clock edge.
        show(1, dg(7, 1'b0), 8);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        dig_in = 4'hF;
        seg_in = 8'hFF;
        @(negedge clk_in);
        @(negedge clk_in);
        reset = 1'b1;
        idle_bus(4);

        // Post-reset pass over slots 1..0 only; stale shadow must not leak in.
        show(1, dg(7, 1'b0), HOLD);
        show(0, dg(2, 1'b0), HOLD);
        exp_q.push_back(mk(16'h0072, 4'b1100, 4'b0000, 4'b0000));
        show(1, dg(7, 1'b0), HOLD);
        show(0, dg(2, 1'b0), HOLD);
        idle_bus(20);

        check("frames_outstanding", 16'(exp_q.size()), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
